// File: rtl/control_pkg.sv
// control_pkg
//   Shared definitions for the multicycle RV32I-subset control unit:
//   FSM state encoding, opcode constants, immediate-format codes for the
//   sign extender, ALU control codes and the internal aluOp selector.
package control_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BEQ,
        S_JAL
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder
//   Combinational ALU operation decode.
//   Ports:
//     aluop_i       in  2  ADD / SUB / FUNCT request from the FSM
//     funct3_i      in  3  instr[14:12]
//     funct7b5_i    in  1  instr[30]
//     op5_i         in  1  instr[5], distinguishes R-type from I-type
//     alu_control_o out 3  ALU operation code
module alu_decoder
    import control_pkg::*;
(
    input  logic [1:0] aluop_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic       op5_i,
    output logic [2:0] alu_control_o
);

    always_comb begin
        alu_control_o = ALU_ADD;
        case (aluop_i)
            ALUOP_SUB: alu_control_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3_i)
                    // funct7b5 only means sub for register operands; for
                    // addi that bit belongs to the immediate.
                    3'b000:  alu_control_o = (op5_i & funct7b5_i) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control_o = ALU_SLT;
                    3'b110:  alu_control_o = ALU_OR;
                    3'b111:  alu_control_o = ALU_AND;
                    default: alu_control_o = ALU_ADD;
                endcase
            end
            default: alu_control_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/control_multiciclo.sv
// control_multiciclo
//   Multicycle RV32I-subset control FSM (lw, sw, R-type, I-ALU, beq, jal).
//   One state per clock; outputs are Moore functions of the state except
//   pcWrite (depends on zero in BEQ), immSrc and aluControl (depend on op/funct).
//   Ports:
//     clk, reset                 rising-edge clock, async active-high reset
//     op, funct3, funct7b5, zero instruction fields and ALU zero flag
//     pcWrite, adrSrc, memWrite, irWrite, regWrite   datapath enables/selects
//     resultSrc, aluSrcA, aluSrcB, immSrc, aluControl datapath mux/op codes
//     illegalOp                  one-cycle pulse in DECODE on unknown opcode
module control_multiciclo
    import control_pkg::*;
#(
    parameter int ILLEGAL_FLAG = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       pcWrite,
    output logic       adrSrc,
    output logic       memWrite,
    output logic       irWrite,
    output logic       regWrite,
    output logic [1:0] resultSrc,
    output logic [1:0] aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] immSrc,
    output logic [2:0] aluControl,
    output logic       illegalOp
);

    state_t state_q;
    state_t state_d;
    aluop_t alu_op;
    logic   illegal_raw;

    // Async reset: outputs are decoded from state_q, so write enables drop
    // as soon as reset asserts, without waiting for a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = S_FETCH;
        pcWrite     = 1'b0;
        adrSrc      = 1'b0;
        memWrite    = 1'b0;
        irWrite     = 1'b0;
        regWrite    = 1'b0;
        resultSrc   = 2'b00;
        aluSrcA     = 2'b00;
        aluSrcB     = 2'b00;
        alu_op      = ALUOP_ADD;
        illegal_raw = 1'b0;
        case (state_q)
            S_FETCH: begin
                irWrite   = 1'b1;
                aluSrcB   = 2'b10;
                resultSrc = 2'b10;
                pcWrite   = 1'b1;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                // PC-relative target is computed here for a possible branch.
                aluSrcA = 2'b01;
                aluSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTER;
                    OP_ITYPE:     state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default: begin
                        illegal_raw = 1'b1;
                        state_d     = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                aluSrcA = 2'b10;
                aluSrcB = 2'b01;
                state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adrSrc  = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                resultSrc = 2'b01;
                regWrite  = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                adrSrc   = 1'b1;
                memWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_EXECUTER: begin
                aluSrcA = 2'b10;
                alu_op  = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_EXECUTEI: begin
                aluSrcA = 2'b10;
                aluSrcB = 2'b01;
                alu_op  = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                regWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BEQ: begin
                aluSrcA = 2'b10;
                alu_op  = ALUOP_SUB;
                pcWrite = zero;
                state_d = S_FETCH;
            end
            S_JAL: begin
                // PC+4 is formed here as the link value; ALUWB writes it back.
                aluSrcA = 2'b01;
                aluSrcB = 2'b10;
                pcWrite = 1'b1;
                state_d = S_ALUWB;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        immSrc = IMM_I;
        case (op)
            OP_SW:   immSrc = IMM_S;
            OP_BEQ:  immSrc = IMM_B;
            OP_JAL:  immSrc = IMM_J;
            default: immSrc = IMM_I;
        endcase
    end

    assign illegalOp = (ILLEGAL_FLAG != 0) && illegal_raw;

    alu_decoder u_alu_decoder (
        .aluop_i       (alu_op),
        .funct3_i      (funct3),
        .funct7b5_i    (funct7b5),
        .op5_i         (op[5]),
        .alu_control_o (aluControl)
    );

endmodule

// File: tb/tb_control_multiciclo.sv
// tb_control_multiciclo
//   Scoreboard bench: for each instruction the expected per-cycle output
//   vectors are queued when the instruction is driven, then popped and
//   compared once per cycle, half a period after the state changes.
module tb_control_multiciclo;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       pcWrite, adrSrc, memWrite, irWrite, regWrite, illegalOp;
    logic [1:0] resultSrc, aluSrcA, aluSrcB, immSrc;
    logic [2:0] aluControl;

    int checks   = 0;
    int failures = 0;

    logic [16:0] exp_q[$];
    string       tag_q[$];

    control_multiciclo #(.ILLEGAL_FLAG(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .zero       (zero),
        .pcWrite    (pcWrite),
        .adrSrc     (adrSrc),
        .memWrite   (memWrite),
        .irWrite    (irWrite),
        .regWrite   (regWrite),
        .resultSrc  (resultSrc),
        .aluSrcA    (aluSrcA),
        .aluSrcB    (aluSrcB),
        .immSrc     (immSrc),
        .aluControl (aluControl),
        .illegalOp  (illegalOp)
    );

    always #5 clk = ~clk;

    logic [16:0] obs;
    assign obs = {pcWrite, adrSrc, memWrite, irWrite, regWrite, resultSrc,
                  aluSrcA, aluSrcB, immSrc, aluControl, illegalOp};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] fv(input logic pcw, input logic adr, input logic memw,
                                       input logic irw, input logic regw, input logic [1:0] res,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] imm, input logic [2:0] alu,
                                       input logic ill);
        return {pcw, adr, memw, irw, regw, res, a, b, imm, alu, ill};
    endfunction

    task automatic push(input string t, input logic [16:0] v);
        tag_q.push_back(t);
        exp_q.push_back(v);
    endtask

    // Called just after a falling edge; checks n cycles, one per falling edge.
    task automatic drain(input int n);
        string       t;
        logic [16:0] e;
        for (int i = 0; i < n; i++) begin
            #1;
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", 32'd0, 32'd1);
            end else begin
                t = tag_q.pop_front();
                e = exp_q.pop_front();
                check(t, {15'd0, obs}, {15'd0, e});
            end
            @(negedge clk);
        end
    endtask

    function automatic logic [1:0] imm_of(input logic [6:0] o);
        case (o)
            7'b0100011: return 2'b01;
            7'b1100011: return 2'b10;
            7'b1101111: return 2'b11;
            default:    return 2'b00;
        endcase
    endfunction

    task automatic run_instr(input string nm, input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input logic z, input logic [2:0] alu_e);
        logic [1:0] im;
        op = o; funct3 = f3; funct7b5 = f7; zero = z;
        im = imm_of(o);
        push({nm, "_fetch"}, fv(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, im, 3'b000, 0));
        if (o inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111})
            push({nm, "_decode"}, fv(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, im, 3'b000, 0));
        else
            push({nm, "_decode_illegal"}, fv(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, im, 3'b000, 1));
        case (o)
            7'b0000011: begin
                push({nm, "_memadr"},  fv(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, im, 3'b000, 0));
                push({nm, "_memread"}, fv(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, im, 3'b000, 0));
                push({nm, "_memwb"},   fv(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, im, 3'b000, 0));
            end
            7'b0100011: begin
                push({nm, "_memadr"},   fv(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, im, 3'b000, 0));
                push({nm, "_memwrite"}, fv(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, im, 3'b000, 0));
            end
            7'b0110011: begin
                push({nm, "_execr"}, fv(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, im, alu_e, 0));
                push({nm, "_aluwb"}, fv(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, im, 3'b000, 0));
            end
            7'b0010011: begin
                push({nm, "_execi"}, fv(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, im, alu_e, 0));
                push({nm, "_aluwb"}, fv(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, im, 3'b000, 0));
            end
            7'b1100011: push({nm, "_beq"}, fv(z, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, im, 3'b001, 0));
            7'b1101111: begin
                push({nm, "_jal"},   fv(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, im, 3'b000, 0));
                push({nm, "_aluwb"}, fv(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, im, 3'b000, 0));
            end
            default: ;
        endcase
        drain(exp_q.size());
    endtask

    initial begin
        reset = 1'b1; op = 7'b0000011; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
        @(negedge clk);
        #1;
        check("rst_irWrite",  {31'd0, irWrite},  32'd1);
        check("rst_pcWrite",  {31'd0, pcWrite},  32'd1);
        check("rst_aluSrcB",  {30'd0, aluSrcB},  32'd2);
        check("rst_memWrite", {31'd0, memWrite}, 32'd0);
        check("rst_regWrite", {31'd0, regWrite}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_instr("lw",        7'b0000011, 3'b010, 0, 0, 3'b000);
        run_instr("sw",        7'b0100011, 3'b010, 0, 0, 3'b000);
        run_instr("beq_z1",    7'b1100011, 3'b000, 0, 1, 3'b000);
        run_instr("beq_z0",    7'b1100011, 3'b000, 0, 0, 3'b000);
        run_instr("r_sub",     7'b0110011, 3'b000, 1, 0, 3'b001);
        run_instr("r_add",     7'b0110011, 3'b000, 0, 0, 3'b000);
        run_instr("i_addi",    7'b0010011, 3'b000, 1, 0, 3'b000);
        run_instr("r_slt",     7'b0110011, 3'b010, 0, 0, 3'b101);
        run_instr("r_or",      7'b0110011, 3'b110, 0, 0, 3'b011);
        run_instr("r_and",     7'b0110011, 3'b111, 0, 0, 3'b010);
        run_instr("i_slti",    7'b0010011, 3'b010, 0, 0, 3'b101);
        run_instr("i_ori",     7'b0010011, 3'b110, 1, 0, 3'b011);
        run_instr("r_other",   7'b0110011, 3'b001, 1, 0, 3'b000);
        run_instr("jal",       7'b1101111, 3'b000, 0, 1, 3'b000);
        run_instr("illegal",   7'b1111111, 3'b000, 0, 0, 3'b000);
        run_instr("after_ill", 7'b0010011, 3'b111, 0, 0, 3'b010);

        // Reset in the middle of a store: memWrite must drop without a clock edge.
        op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
        push("rmid_fetch",    fv(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000, 0));
        push("rmid_decode",   fv(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b01, 3'b000, 0));
        push("rmid_memadr",   fv(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 0));
        drain(3);
        #1;
        check("rmid_memwrite_before", {31'd0, memWrite}, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("rmid_memwrite_after", {31'd0, memWrite}, 32'd0);
        check("rmid_fetch_outputs", {15'd0, obs},
              {15'd0, fv(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000, 0)});
        @(negedge clk);
        reset = 1'b0;
        run_instr("post_reset_beq", 7'b1100011, 3'b000, 0, 1, 3'b000);

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/control_multiciclo.md
Name: control_multiciclo

Overview:
Multicycle RV32I-subset control unit. It sequences the shared datapath (PC, instruction register, sign extender, ALU, register file, memory) one state per clock. Each cycle it drives the immediate-format select `immSrc` for the SE block, the ALU operation, the mux selects and the write enables. It sits between the instruction register and the datapath.

Parameters:
- ILLEGAL_FLAG, default 1: when 1, `illegalOp` pulses on an unknown opcode. When 0, `illegalOp` is tied to 0.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; forces state FETCH
- op  in  7  instr[6:0] from instruction register
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU zero flag
- pcWrite  out  1  PC load enable
- adrSrc  out  1  memory address select: 0=PC, 1=ALU result register
- memWrite  out  1  data memory write enable
- irWrite  out  1  instruction register load
- regWrite  out  1  register file write
- resultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- aluSrcA  out  2  00=PC, 01=OldPC, 10=rs1 register
- aluSrcB  out  2  00=rs2 register, 01=immExt, 10=constant 4
- immSrc  out  2  to SE: 00=I, 01=S, 10=B, 11=J
- aluControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- illegalOp  out  1  one-cycle pulse in DECODE on an unsupported opcode

Behaviour:
- State register: asynchronous reset to FETCH. All other outputs are a combinational (Moore) function of state, except:
  - `pcWrite`, which also depends on `zero`;
  - `immSrc` and `aluControl`, which also depend on `op`/`funct`.
- Outputs not listed for a state are 0. After reset, outputs equal the FETCH values below.
- FETCH: `adrSrc`=0, `irWrite`=1, `aluSrcA`=00, `aluSrcB`=10, aluOp=add, `resultSrc`=10, `pcWrite`=1. Next state: DECODE.
- DECODE: `aluSrcA`=01, `aluSrcB`=01, aluOp=add (branch target precompute). Next state by `op`:
  - 0000011 (lw) or 0100011 (sw) -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - other -> FETCH, with `illegalOp`=1 for this cycle.
- MEMADR: `aluSrcA`=10, `aluSrcB`=01, add. Next: MEMREAD if op=lw, else MEMWRITE.
- MEMREAD: `resultSrc`=00, `adrSrc`=1. Next: MEMWB.
- MEMWB: `resultSrc`=01, `regWrite`=1. Next: FETCH.
- MEMWRITE: `resultSrc`=00, `adrSrc`=1, `memWrite`=1. Next: FETCH.
- EXECUTER: `aluSrcA`=10, `aluSrcB`=00, aluOp=funct. Next: ALUWB.
- EXECUTEI: `aluSrcA`=10, `aluSrcB`=01, aluOp=funct. Next: ALUWB.
- ALUWB: `resultSrc`=00, `regWrite`=1. Next: FETCH.
- BEQ: `aluSrcA`=10, `aluSrcB`=00, aluOp=sub, `resultSrc`=00, `pcWrite`=`zero`. Next: FETCH.
- JAL: `aluSrcA`=01, `aluSrcB`=10, add, `resultSrc`=00, `pcWrite`=1. Next: ALUWB.
- `immSrc` is decoded from `op` in every state: lw/I-ALU=00, sw=01, beq=10, jal=11, unknown=00.
- ALU decode for aluOp=funct:
  - funct3 000 -> sub if (op[5] & funct7b5), else add
  - funct3 010 -> slt
  - funct3 110 -> or
  - funct3 111 -> and
  - other funct3 -> add
- Instruction latency in cycles: beq 3; sw, R-type, I-type, jal 4; lw 5.
- Reset mid-instruction: the state goes to FETCH immediately, with no wait for a clock edge. Write enables drop in the same delta, so no partial memory or register write completes after reset asserts.
- Inputs are sampled only through combinational decode. `op` must be stable from DECODE until the return to FETCH, which holds because `irWrite` is asserted only in FETCH.
- Unreachable state encodings go to FETCH.

Decomposition:
- Package `control_pkg` holds:
  - state enum (11 states);
  - opcode constants;
  - `immSrc` codes (IMM_I/S/B/J);
  - aluControl codes;
  - aluOp codes (ADD/SUB/FUNCT).
- One sub-module `alu_decoder` (combinational: aluOp, funct3, funct7b5, op[5] -> aluControl).
- `immSrc` decode stays inline.

Test Plan:
- Reset pulsed for 2 cycles, then released. Until the first edge: `irWrite`=1, `pcWrite`=1, `aluSrcB`=10, `memWrite`=0, `regWrite`=0. State sequence FETCH -> DECODE.
- op=0000011 (lw). States FETCH, DECODE, MEMADR, MEMREAD, MEMWB over 5 cycles. `immSrc`=00; `regWrite`=1 only in cycle 5 with `resultSrc`=01.
- op=0100011 (sw), then op=1100011 (beq) run twice, once with zero=1 and once with zero=0:
  - sw: `memWrite`=1 only in cycle 4, `immSrc`=01.
  - beq: `pcWrite`=1 in cycle 3 only when zero=1; `aluControl`=001; `immSrc`=10.
- op=0110011 with funct3=000 and funct7b5=1: `aluControl`=001 in EXECUTER. Same with op=0010011 and funct7b5=1: `aluControl`=000 (addi, not sub). funct3=010 gives 101; 110 gives 011; 111 gives 010.
- op=1101111 (jal). States FETCH, DECODE, JAL, ALUWB. `immSrc`=11; `pcWrite`=1 in the JAL state; `regWrite`=1 in ALUWB.
- op=1111111 gives `illegalOp`=1 for one cycle in DECODE, then FETCH. Separately, reset asserted during MEMWRITE gives `memWrite`=0 within the same timestep and the state returns to FETCH.
